// File: rtl/edge_evt_pkg.sv
// Shared encodings for the edge-event arbiter: edge-mode selectors and the
// two-state grant FSM.
package edge_evt_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/edge_pending_cell.sv
// One channel of the arbiter: two-register edge detector, pending flag with
// captured polarity, and a sticky overflow bit for edges that could not be held.
module edge_pending_cell
  import edge_evt_pkg::*;
#(
  parameter int EDGE_MODE = EDGE_BOTH
) (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  input  logic mask,
  input  logic ack_this,
  input  logic clr_ovf,
  output logic pending,
  output logic pol,
  output logic overflow
);

  logic r0;
  logic r1;
  logic rise;
  logic fall;
  logic edge_seen;
  logic lost;

  assign rise      = r0 & ~r1 & (EDGE_MODE != EDGE_FALL);
  assign fall      = ~r0 & r1 & (EDGE_MODE != EDGE_RISE);
  assign edge_seen = (rise | fall) & ~mask;
  // A second edge while the first is still unserved is dropped; the first keeps its polarity.
  assign lost      = edge_seen & pending & ~ack_this;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r0 <= 1'b0;
      r1 <= 1'b0;
    end else begin
      r0 <= sinal;
      r1 <= r0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      pol     <= 1'b0;
    end else if (edge_seen && (!pending || ack_this)) begin
      pending <= 1'b1;
      pol     <= rise;
    end else if (ack_this) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (lost) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: latches edges per channel and presents
// them one at a time to a single consumer in round-robin order.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N         = 4,
  parameter int IDW       = 2,
  parameter int EDGE_MODE = EDGE_BOTH
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   sinal,
  input  logic [N-1:0]   mask,
  input  logic           evt_ack,
  input  logic           clear_overflow,
  output logic           evt_valid,
  output logic [IDW-1:0] evt_id,
  output logic           evt_rising,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow
);

  localparam logic [IDW:0]   NUM_CH  = (IDW+1)'(N);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N-1);

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] ptr_nx;
  logic [IDW-1:0] id_nx;
  logic           rising_nx;

  logic [N-1:0]   pol;
  logic [N-1:0]   ack_this;

  logic [2*N-1:0] dbl_pend;
  logic [2*N-1:0] dbl_pol;
  logic [N-1:0]   rot_pend;
  logic [N-1:0]   rot_pol;
  logic           sel_found;
  logic           sel_pol;
  logic [IDW-1:0] sel_off;
  logic [IDW:0]   sel_sum;
  logic [IDW-1:0] sel;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign ack_this[i] = (state == ST_GRANT) & evt_ack & (evt_id == IDW'(i));

    edge_pending_cell #(
      .EDGE_MODE (EDGE_MODE)
    ) u_cell (
      .clock    (clock),
      .reset    (reset),
      .sinal    (sinal[i]),
      .mask     (mask[i]),
      .ack_this (ack_this[i]),
      .clr_ovf  (clear_overflow),
      .pending  (pending[i]),
      .pol      (pol[i]),
      .overflow (overflow[i])
    );
  end

  // Rotate so the search always starts at bit 0 = rr_ptr, then map the offset back.
  assign dbl_pend = {pending, pending} >> rr_ptr;
  assign dbl_pol  = {pol, pol} >> rr_ptr;
  assign rot_pend = dbl_pend[N-1:0];
  assign rot_pol  = dbl_pol[N-1:0];

  always_comb begin
    sel_found = 1'b0;
    sel_pol   = 1'b0;
    sel_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_pend[k]) begin
        sel_found = 1'b1;
        sel_off   = IDW'(k);
        sel_pol   = rot_pol[k];
      end
    end
  end

  assign sel_sum = {1'b0, rr_ptr} + {1'b0, sel_off};
  assign sel     = (sel_sum >= NUM_CH) ? IDW'(sel_sum - NUM_CH) : sel_sum[IDW-1:0];

  always_comb begin
    state_nx  = state;
    ptr_nx    = rr_ptr;
    id_nx     = evt_id;
    rising_nx = evt_rising;
    case (state)
      ST_IDLE: begin
        if (sel_found) begin
          id_nx     = sel;
          rising_nx = sel_pol;
          state_nx  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (evt_ack) begin
          ptr_nx   = (evt_id == LAST_ID) ? '0 : evt_id + 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      evt_id     <= '0;
      evt_rising <= 1'b0;
    end else begin
      state      <= state_nx;
      rr_ptr     <= ptr_nx;
      evt_id     <= id_nx;
      evt_rising <= rising_nx;
    end
  end

  // evt_valid comes straight off the state flop, so reset drops it asynchronously.
  assign evt_valid = (state == ST_GRANT);

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against an event-level reference model.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   sinal;
  logic [N-1:0]   mask;
  logic           evt_ack;
  logic           clear_overflow;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_rising;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;

  int checks = 0;
  int passes = 0;
  int gq[$];

  logic [N-1:0] m_s0, m_s1, m_pend, m_pol, m_ovf;
  bit           m_busy, m_rise;
  int           m_id, m_ptr;

  edge_event_arbiter #(.N(N), .IDW(IDW), .EDGE_MODE(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .sinal          (sinal),
    .mask           (mask),
    .evt_ack        (evt_ack),
    .clear_overflow (clear_overflow),
    .evt_valid      (evt_valid),
    .evt_id         (evt_id),
    .evt_rising     (evt_rising),
    .pending        (pending),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Serve events with ack held high, recording each presented event as id*2+rising.
  task automatic collect(input int cycles);
    gq.delete();
    evt_ack = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (evt_valid) gq.push_back(int'(evt_id) * 2 + int'(evt_rising));
      tick();
    end
    evt_ack = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    evt_ack = 1'b1;
    for (int n = 0; n < 48; n++) begin
      tick();
      if (n >= 4 && pending == '0 && !evt_valid) begin
        done = 1'b1;
        break;
      end
    end
    evt_ack = 1'b0;
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++;
    if (done !== 1'b1) $display("FAIL drain_timeout: pending=%b valid=%b, required idle within 48 cycles", pending, evt_valid);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", evt_valid); else passes++;
    checks++; if (evt_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", evt_id); else passes++;
    checks++; if (evt_rising !== 1'b0) $display("FAIL reset_rising: got %b want 0", evt_rising); else passes++;
    checks++; if (pending !== 4'b0000) $display("FAIL reset_pending: got %b want 0000", pending); else passes++;
    checks++; if (overflow !== 4'b0000) $display("FAIL reset_overflow: got %b want 0000", overflow); else passes++;
    reset = 1'b0;
    tick();
    checks++; if (evt_valid !== 1'b0) $display("FAIL post_reset_valid: got %b want 0", evt_valid); else passes++;
  endtask

  task automatic test_single_rise();
    sinal = 4'b0010;
    tick();
    tick();
    checks++; if (pending !== 4'b0010) $display("FAIL single_pending_k1: got %b want 0010", pending); else passes++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL single_valid_k1: got %b want 0", evt_valid); else passes++;
    tick();
    checks++; if (evt_valid !== 1'b1) $display("FAIL single_valid_k2: got %b want 1", evt_valid); else passes++;
    checks++; if (evt_id !== 2'd1) $display("FAIL single_id: got %0d want 1", evt_id); else passes++;
    checks++; if (evt_rising !== 1'b1) $display("FAIL single_rising: got %b want 1", evt_rising); else passes++;
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    checks++; if (evt_valid !== 1'b0) $display("FAIL single_valid_after_ack: got %b want 0", evt_valid); else passes++;
    checks++; if (pending !== 4'b0000) $display("FAIL single_pending_after_ack: got %b want 0000", pending); else passes++;
    sinal = 4'b0000;
    drain();
  endtask

  task automatic test_both_edges();
    gq.delete();
    evt_ack = 1'b1;
    sinal = 4'b1000;
    for (int c = 0; c < 14; c++) begin
      if (c == 5) sinal = 4'b0000;
      if (evt_valid) gq.push_back(int'(evt_id) * 2 + int'(evt_rising));
      tick();
    end
    evt_ack = 1'b0;
    checks++; if (gq.size() != 2) $display("FAIL both_count: got %0d events want 2", gq.size()); else passes++;
    checks++; if ((gq.size() > 0 ? gq[0] : -1) != 7) $display("FAIL both_first: got code %0d want 7 (id3 rise)", gq.size() > 0 ? gq[0] : -1); else passes++;
    checks++; if ((gq.size() > 1 ? gq[1] : -1) != 6) $display("FAIL both_second: got code %0d want 6 (id3 fall)", gq.size() > 1 ? gq[1] : -1); else passes++;
    checks++; if (overflow !== 4'b0000) $display("FAIL both_overflow: got %b want 0000", overflow); else passes++;
  endtask

  task automatic test_round_robin();
    sinal = 4'b1101;
    collect(12);
    checks++; if (gq.size() != 3) $display("FAIL rr1_count: got %0d want 3", gq.size()); else passes++;
    checks++; if ((gq.size() > 0 ? gq[0] : -1) != 1) $display("FAIL rr1_first: got code %0d want 1", gq.size() > 0 ? gq[0] : -1); else passes++;
    checks++; if ((gq.size() > 1 ? gq[1] : -1) != 5) $display("FAIL rr1_second: got code %0d want 5", gq.size() > 1 ? gq[1] : -1); else passes++;
    checks++; if ((gq.size() > 2 ? gq[2] : -1) != 7) $display("FAIL rr1_third: got code %0d want 7", gq.size() > 2 ? gq[2] : -1); else passes++;
    sinal = 4'b0000;
    collect(12);
    sinal = 4'b0001;
    collect(8);
    // pointer now 1: channel 0 falls and channel 3 rises together
    sinal = 4'b1000;
    collect(12);
    checks++; if (gq.size() != 2) $display("FAIL rr2_count: got %0d want 2", gq.size()); else passes++;
    checks++; if ((gq.size() > 0 ? gq[0] : -1) != 7) $display("FAIL rr2_first: got code %0d want 7 (id3 rise)", gq.size() > 0 ? gq[0] : -1); else passes++;
    checks++; if ((gq.size() > 1 ? gq[1] : -1) != 0) $display("FAIL rr2_second: got code %0d want 0 (id0 fall)", gq.size() > 1 ? gq[1] : -1); else passes++;
    sinal = 4'b0000;
    drain();
  endtask

  task automatic test_overflow();
    evt_ack = 1'b0;
    sinal = 4'b0010;
    tick(); tick(); tick();
    sinal = 4'b0000;
    tick(); tick(); tick();
    checks++; if (overflow !== 4'b0010) $display("FAIL ovf_bits: got %b want 0010", overflow); else passes++;
    checks++; if (evt_valid !== 1'b1) $display("FAIL ovf_valid: got %b want 1", evt_valid); else passes++;
    checks++; if (evt_id !== 2'd1) $display("FAIL ovf_id: got %0d want 1", evt_id); else passes++;
    checks++; if (evt_rising !== 1'b1) $display("FAIL ovf_rising: got %b want 1", evt_rising); else passes++;
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    checks++; if (overflow !== 4'b0000) $display("FAIL ovf_clear: got %b want 0000", overflow); else passes++;
    drain();
  endtask

  task automatic test_ack_edge();
    sinal = 4'b0100;
    tick();
    tick();
    sinal = 4'b0000;
    tick();
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_rising !== 1'b1)
      $display("FAIL ackedge_grant: got valid=%b id=%0d rising=%b want 1/2/1", evt_valid, evt_id, evt_rising);
    else passes++;
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    checks++; if (pending[2] !== 1'b1) $display("FAIL ackedge_pending: got %b want 1", pending[2]); else passes++;
    checks++; if (overflow !== 4'b0000) $display("FAIL ackedge_overflow: got %b want 0000", overflow); else passes++;
    tick();
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_rising !== 1'b0)
      $display("FAIL ackedge_second: got valid=%b id=%0d rising=%b want 1/2/0", evt_valid, evt_id, evt_rising);
    else passes++;
    drain();
  endtask

  task automatic test_mask_reset();
    mask = 4'b0001;
    sinal = 4'b0001;
    tick(); tick(); tick(); tick();
    checks++; if (pending !== 4'b0000) $display("FAIL mask_pending: got %b want 0000", pending); else passes++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL mask_valid: got %b want 0", evt_valid); else passes++;
    sinal = 4'b0011;
    tick(); tick(); tick();
    checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd1)
      $display("FAIL midrst_grant: got valid=%b id=%0d want 1/1", evt_valid, evt_id);
    else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (evt_valid !== 1'b0) $display("FAIL midrst_valid_async: got %b want 0", evt_valid); else passes++;
    checks++; if (pending !== 4'b0000) $display("FAIL midrst_pending: got %b want 0000", pending); else passes++;
    sinal = 4'b0000;
    mask = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (evt_id !== 2'd0) $display("FAIL midrst_id: got %0d want 0", evt_id); else passes++;
    tick(); tick(); tick(); tick();
    checks++; if (evt_valid !== 1'b0) $display("FAIL midrst_quiet: got %b want 0", evt_valid); else passes++;
  endtask

  // Event-level reference: edges seen from the last two samples, one pending slot per channel.
  task automatic model_step();
    logic [N-1:0] old_pend, old_pol;
    bit acked, ri, fi, e, ai, lost, found;
    int c;
    old_pend = m_pend;
    old_pol  = m_pol;
    acked    = m_busy && evt_ack;
    for (int i = 0; i < N; i++) begin
      ri   = m_s0[i] && !m_s1[i];
      fi   = !m_s0[i] && m_s1[i];
      e    = (ri || fi) && !mask[i];
      ai   = acked && (m_id == i);
      lost = e && old_pend[i] && !ai;
      if (e && (!old_pend[i] || ai)) begin
        m_pend[i] = 1'b1;
        m_pol[i]  = ri;
      end else if (ai) begin
        m_pend[i] = 1'b0;
      end
      if (lost) m_ovf[i] = 1'b1;
      else if (clear_overflow) m_ovf[i] = 1'b0;
    end
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && old_pend[c]) begin
          found  = 1'b1;
          m_busy = 1'b1;
          m_id   = c;
          m_rise = old_pol[c];
        end
      end
    end else if (evt_ack) begin
      m_busy = 1'b0;
      m_ptr  = (m_id + 1) % N;
    end
    m_s1 = m_s0;
    m_s0 = sinal;
  endtask

  task automatic test_random();
    logic [11:0] got, want;
    logic [1:0]  idv;
    sinal = '0; mask = '0; evt_ack = 1'b0; clear_overflow = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_s0 = '0; m_s1 = '0; m_pend = '0; m_pol = '0; m_ovf = '0;
    m_busy = 1'b0; m_rise = 1'b0; m_id = 0; m_ptr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) sinal[b] = ~sinal[b];
      if (cyc % 25 == 0) mask = N'($urandom & $urandom & $urandom);
      evt_ack        = ($urandom_range(0, 2) != 0);
      clear_overflow = ($urandom_range(0, 15) == 0);
      model_step();
      tick();
      idv  = m_id[1:0];
      got  = {pending, overflow, evt_valid, evt_id, evt_rising};
      want = {m_pend, m_ovf, m_busy, idv, m_rise};
      checks++;
      if (got !== want)
        $display("FAIL random_cycle%0d: got pend=%b ovf=%b v=%b id=%0d r=%b want pend=%b ovf=%b v=%b id=%0d r=%b",
                 cyc, pending, overflow, evt_valid, evt_id, evt_rising, m_pend, m_ovf, m_busy, idv, m_rise);
      else passes++;
    end
    evt_ack = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    sinal = '0;
    mask = '0;
    evt_ack = 1'b0;
    clear_overflow = 1'b0;
    test_reset();
    test_single_rise();
    test_both_edges();
    test_round_robin();
    test_overflow();
    test_ack_edge();
    test_mask_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
